elevator_cabin_model: RTL and testbench
=======================================

Name: elevator_cabin_model

Overview:
Synthesizable plant model of the elevator cabin, hoist and door. It sits on the far side of the floor-controller's motor/door command interface. It consumes motor_up/motor_down/door_cmd and returns the cabin's floor position, arrival pulses and door status, so the controller can be closed-loop simulated and demoed on the board without real hardware.

Parameters:
NUM_FLOORS, 4, number of floors (floor 0 = first floor)
FLOOR_BITS, 2, width of floor index; must satisfy 2^FLOOR_BITS >= NUM_FLOORS
TRAVEL_CYCLES, 8, clock cycles to travel between adjacent floors (>= 2)
DOOR_CYCLES, 4, clock cycles the door stays open per door command (>= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
motor_up  input  1  controller request to move cabin up one floor, level-sensitive
motor_down  input  1  controller request to move cabin down one floor, level-sensitive
door_cmd  input  1  request to open the door, level-sensitive
actualFloor  output  FLOOR_BITS  current or last-passed floor
arrive_pulse  output  1  one-cycle pulse when the cabin reaches a floor
moving  output  1  high while the cabin is between floors
dir_up  output  1  direction of the current or last move; 1 = up
door_open  output  1  door physically open
fault  output  1  illegal command detected (see Behaviour)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: actualFloor=0, arrive_pulse=0, moving=0, dir_up=1, door_open=0, fault=0, state=IDLE, travel counter=0, door counter=0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE, evaluated in this priority order:
  - motor_up && motor_down -> fault; stay in IDLE.
  - motor_up with actualFloor==NUM_FLOORS-1 -> fault; stay in IDLE.
  - motor_down with actualFloor==0 -> fault; stay in IDLE.
  - Otherwise motor_up -> MOVE_UP, dir_up=1.
  - Otherwise motor_down -> MOVE_DOWN, dir_up=0.
  - Otherwise door_cmd -> DOOR.
  - Motor requests win over door_cmd when both are asserted.
- MOVE_UP/MOVE_DOWN:
  - moving=1; travel counter increments every cycle from 0.
  - On the edge where counter==TRAVEL_CYCLES-1: actualFloor changes by ±1 (no wrap); arrive_pulse=1 for exactly the next cycle; counter clears.
  - The cabin never stops between floors. Dropping the motor command mid-travel does not abort; the cabin completes the floor.
  - At arrival, if the same-direction command is still high and the next floor exists, the cabin continues with no idle cycle (moving stays 1). Otherwise -> IDLE, moving=0.
  - Latency: command sampled in IDLE at edge N -> actualFloor updates at edge N+TRAVEL_CYCLES.
  - Opposite-direction command or door_cmd while moving -> fault; command ignored.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, then IDLE with door_open=0.
  - door_cmd held through closing reopens only after passing one IDLE cycle.
  - Motor command while in DOOR -> fault; ignored. The cabin never moves with door_open=1.
- Arithmetic: actualFloor is saturating by construction. Counters are $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)) bits wide.
- Reset mid-operation: immediate return to reset values, including mid-travel (cabin modelled at floor 0).

Optional Feature:
Macro FAULT_STICKY_EN.
- Defined: fault is sticky; once set it stays 1 until reset.
- Undefined: fault is a one-cycle pulse per illegal-command cycle.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package elevator_pkg:
  - cabin state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR)
  - NUM_FLOORS default and FLOOR_BITS constant
  - floor index typedef, shared with the floor controller and 7-segment display path
- One natural sub-module: cabin_timer, a clearable up-counter with terminal-count flag. It is instantiated twice, once for travel and once for door timing.

Test Plan:
- Reset release, then motor_up held 1 cycle at floor 0 -> moving=1 for 8 cycles; actualFloor=1 and arrive_pulse at edge +8; then IDLE, moving=0.
- motor_up held continuously from floor 0 -> arrive_pulses at +8, +16, +24; floors 1, 2, 3; then fault=1 with no further movement at floor 3.
- Floor 2 with motor_up && motor_down asserted together -> fault, actualFloor stays 2, moving=0.
- door_cmd in IDLE at floor 1 -> door_open=1 for exactly 4 cycles. motor_down asserted during the door phase -> fault, no move until the door closes.
- Assert reset at cycle 5 of a floor 2 -> 3 travel -> actualFloor=0, moving=0, fault=0 immediately, with no clock edge needed.
- Illegal command followed by 10 idle cycles -> fault stays 1 with FAULT_STICKY_EN; with the macro undefined, fault is high for exactly 1 cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared cabin definitions: state encoding, default floor geometry and the
// floor index type used by the controller, the cabin model and the display path.
package elevator_pkg;

  localparam int CABIN_NUM_FLOORS = 4;
  localparam int CABIN_FLOOR_BITS = 2;

  typedef logic [CABIN_FLOOR_BITS-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } cabin_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cabin_timer.sv
// Clearable free-running up-counter with a terminal-count flag; used for both
// the travel and the door timing of the cabin model.
module cabin_timer #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_r;

  // Count every cycle unless held clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_r + WIDTH'(1);
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/elevator_cabin_model.sv
// Plant model of cabin, hoist and door driven by the floor controller's motor/door
// commands. Define FAULT_STICKY_EN to make fault latch until reset.
module elevator_cabin_model
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = CABIN_NUM_FLOORS,
  parameter int FLOOR_BITS    = CABIN_FLOOR_BITS,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  motor_up,
  input  logic                  motor_down,
  input  logic                  door_cmd,
  output logic [FLOOR_BITS-1:0] actualFloor,
  output logic                  arrive_pulse,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  fault
);

  localparam int CNT_W = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES));
  localparam logic [FLOOR_BITS-1:0] TOP_FLOOR  = FLOOR_BITS'(NUM_FLOORS - 1);
  localparam logic [FLOOR_BITS-1:0] ONE_FLOOR  = FLOOR_BITS'(1);
  localparam logic [FLOOR_BITS-1:0] BASE_FLOOR = {FLOOR_BITS{1'b0}};

  cabin_state_e state_r;
  logic travel_tc_s;
  logic door_tc_s;
  logic travel_clear_s;
  logic door_clear_s;
  logic illegal_s;
  logic fault_next_s;
  logic at_top_s;
  logic at_bottom_s;

  cabin_timer #(.WIDTH(CNT_W), .TERMINAL(TRAVEL_CYCLES - 1)) u_travel_timer (
    .clk   (clk),
    .rst_n (reset),
    .clear (travel_clear_s),
    .tc    (travel_tc_s)
  );

  cabin_timer #(.WIDTH(CNT_W), .TERMINAL(DOOR_CYCLES - 1)) u_door_timer (
    .clk   (clk),
    .rst_n (reset),
    .clear (door_clear_s),
    .tc    (door_tc_s)
  );

  // Timer control and illegal-command detection for the current state.
  always_comb begin
    travel_clear_s = 1'b1;
    door_clear_s   = 1'b1;
    illegal_s      = 1'b0;
    at_top_s       = (actualFloor == TOP_FLOOR);
    at_bottom_s    = (actualFloor == BASE_FLOOR);
    case (state_r)
      IDLE: begin
        illegal_s = (motor_up && motor_down) || (motor_up && at_top_s) ||
                    (motor_down && at_bottom_s);
      end
      MOVE_UP: begin
        travel_clear_s = travel_tc_s;
        illegal_s      = motor_down || door_cmd;
      end
      MOVE_DOWN: begin
        travel_clear_s = travel_tc_s;
        illegal_s      = motor_up || door_cmd;
      end
      DOOR: begin
        door_clear_s = door_tc_s;
        illegal_s    = motor_up || motor_down;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
`ifdef FAULT_STICKY_EN
    fault_next_s = fault || illegal_s;
`else
    fault_next_s = illegal_s;
`endif
  end

  // Cabin FSM with all outputs registered; an illegal command never changes state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      actualFloor  <= BASE_FLOOR;
      arrive_pulse <= 1'b0;
      moving       <= 1'b0;
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      arrive_pulse <= 1'b0;
      fault        <= fault_next_s;
      case (state_r)
        IDLE: begin
          if (illegal_s) begin
            state_r <= IDLE;
          end else if (motor_up) begin
            state_r <= MOVE_UP;
            dir_up  <= 1'b1;
            moving  <= 1'b1;
          end else if (motor_down) begin
            state_r <= MOVE_DOWN;
            dir_up  <= 1'b0;
            moving  <= 1'b1;
          end else if (door_cmd) begin
            state_r   <= DOOR;
            door_open <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        MOVE_UP: begin
          if (travel_tc_s) begin
            actualFloor  <= actualFloor + ONE_FLOOR;
            arrive_pulse <= 1'b1;
            // Keep going without an idle cycle only if another floor lies above.
            if (motor_up && ((actualFloor + ONE_FLOOR) != TOP_FLOOR)) begin
              state_r <= MOVE_UP;
            end else begin
              state_r <= IDLE;
              moving  <= 1'b0;
            end
          end
        end
        MOVE_DOWN: begin
          if (travel_tc_s) begin
            actualFloor  <= actualFloor - ONE_FLOOR;
            arrive_pulse <= 1'b1;
            if (motor_down && (actualFloor != ONE_FLOOR)) begin
              state_r <= MOVE_DOWN;
            end else begin
              state_r <= IDLE;
              moving  <= 1'b0;
            end
          end
        end
        DOOR: begin
          if (door_tc_s) begin
            state_r   <= IDLE;
            door_open <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_cabin_model.sv
// Directed bench for elevator_cabin_model: expectations are queued with a due
// cycle when stimulus is applied and compared on the falling edge they mature.
module tb_elevator_cabin_model;
  import elevator_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   motor_up = 1'b0;
  logic   motor_down = 1'b0;
  logic   door_cmd = 1'b0;
  floor_t actual_floor;
  logic   arrive_pulse, moving, dir_up, door_open, fault;

  elevator_cabin_model dut (
    .clk          (clk),
    .reset        (reset),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_cmd     (door_cmd),
    .actualFloor  (actual_floor),
    .arrive_pulse (arrive_pulse),
    .moving       (moving),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .fault        (fault)
  );

  always #5 clk = ~clk;

`ifdef FAULT_STICKY_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          due;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [31:0] obs;

  assign obs = {25'd0, actual_floor, arrive_pulse, moving, dir_up, door_open, fault};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pk(input int fl, input bit arr, input bit mov,
                                     input bit dir, input bit door, input bit flt);
    return {25'd0, fl[1:0], arr, mov, dir, door, flt};
  endfunction

  task automatic compare(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic exp_at(input string tag, input int delay, input logic [31:0] e);
    sb_q.push_back('{tag, cyc + delay, e});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Retire every queued expectation that falls due on this falling edge.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        compare(sb_q[i].tag, obs, sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    tick(3);
    #1 compare("reset_hold", obs, pk(0, 0, 0, 1, 0, 0));
    tick(1);
    reset = 1'b1;
    exp_at("rst_idle", 1, pk(0, 0, 0, 1, 0, 0));
    tick(1);

    // single-floor move up, command held one cycle
    motor_up = 1'b1;
    exp_at("t1_move", 1, pk(0, 0, 1, 1, 0, 0));
    exp_at("t1_move_end", 8, pk(0, 0, 1, 1, 0, 0));
    exp_at("t1_arrive", 9, pk(1, 1, 0, 1, 0, 0));
    exp_at("t1_idle", 10, pk(1, 0, 0, 1, 0, 0));
    tick(1);
    motor_up = 1'b0;
    tick(9);

    // door cycle at floor 1 with motor_down arriving during the door phase
    door_cmd = 1'b1;
    exp_at("d_open1", 1, pk(1, 0, 0, 1, 1, 0));
    exp_at("d_fault", 2, pk(1, 0, 0, 1, 1, 1));
    exp_at("d_open4", 4, pk(1, 0, 0, 1, 1, 1));
    exp_at("d_closed", 5, pk(1, 0, 0, 1, 0, 1));
    exp_at("d_move", 6, pk(1, 0, 1, 0, 0, F));
    exp_at("d_arrive", 14, pk(0, 1, 0, 0, 0, F));
    exp_at("d_idle", 15, pk(0, 0, 0, 0, 0, F));
    tick(1);
    door_cmd   = 1'b0;
    motor_down = 1'b1;
    tick(5);
    motor_down = 1'b0;
    tick(9);

    // one-cycle illegal command at floor 0, then ten quiet cycles
    motor_down = 1'b1;
    exp_at("p_fault", 1, pk(0, 0, 0, 0, 0, 1));
    exp_at("p_after", 2, pk(0, 0, 0, 0, 0, F));
    exp_at("p_after10", 11, pk(0, 0, 0, 0, 0, F));
    tick(1);
    motor_down = 1'b0;
    tick(11);
    reset = 1'b0;
    #1 compare("rst_clear", obs, pk(0, 0, 0, 1, 0, 0));
    tick(1);
    reset = 1'b1;
    exp_at("rst_idle2", 1, pk(0, 0, 0, 1, 0, 0));
    tick(1);

    // motor_up held from floor 0 to the top floor
    motor_up = 1'b1;
    exp_at("u_last", 8, pk(0, 0, 1, 1, 0, 0));
    exp_at("u_f1", 9, pk(1, 1, 1, 1, 0, 0));
    exp_at("u_mid", 10, pk(1, 0, 1, 1, 0, 0));
    exp_at("u_f2", 17, pk(2, 1, 1, 1, 0, 0));
    exp_at("u_f3", 25, pk(3, 1, 0, 1, 0, 0));
    exp_at("u_top_fault", 26, pk(3, 0, 0, 1, 0, 1));
    exp_at("u_top_hold", 27, pk(3, 0, 0, 1, 0, 1));
    tick(27);
    motor_up = 1'b0;
    exp_at("u_release", 1, pk(3, 0, 0, 1, 0, F));
    tick(1);

    // down to floor 2, then both motor commands together
    motor_down = 1'b1;
    exp_at("b_arrive", 9, pk(2, 1, 0, 0, 0, F));
    tick(1);
    motor_down = 1'b0;
    tick(8);
    motor_up   = 1'b1;
    motor_down = 1'b1;
    exp_at("b_fault", 1, pk(2, 0, 0, 0, 0, 1));
    tick(1);
    motor_up   = 1'b0;
    motor_down = 1'b0;
    exp_at("b_idle", 1, pk(2, 0, 0, 0, 0, F));
    tick(1);

    // asynchronous reset in the middle of a floor 2 -> 3 travel
    motor_up = 1'b1;
    exp_at("m_travel", 5, pk(2, 0, 1, 1, 0, F));
    tick(1);
    motor_up = 1'b0;
    tick(4);
    #2 reset = 1'b0;
    #1 compare("m_reset_async", obs, pk(0, 0, 0, 1, 0, 0));
    tick(1);
    reset    = 1'b1;
    motor_up = 1'b1;
    exp_at("m_restart", 1, pk(0, 0, 1, 1, 0, 0));
    exp_at("m_arrive", 9, pk(1, 1, 0, 1, 0, 0));
    tick(1);
    motor_up = 1'b0;
    tick(10);

    compare("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
